// File: rtl/result_reader_pkg.sv
// Shared widths, FSM states and beat payload for the buffer P readback engine.
// A buffer P line packs 8 result words; word w sits at bits [w*WORD_WIDTH +: WORD_WIDTH].
package result_reader_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int WORD_WIDTH = 32;
    localparam int LINE_WORDS = 8;
    localparam int LINE_WIDTH = LINE_WORDS * WORD_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [WORD_WIDTH-1:0] word;
    } beat_t;

    function automatic logic [WORD_WIDTH-1:0] select_word(
        input logic [LINE_WIDTH-1:0] line,
        input logic [2:0]            idx
    );
        return line[idx*WORD_WIDTH +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/result_reader_fifo2.sv
// Two-entry synchronous FIFO carrying {last, word} beats between buffer P and the stream port.
module fifo2
    import result_reader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  beat_t      din,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] count,
    output logic       empty,
    output logic       full
);

    beat_t mem [2];
    logic  rd_ptr;
    logic  wr_ptr;
    logic  do_push;
    logic  do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    assign head  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_reader.sv
// Streams the M x N product matrix out of buffer P in row-major order, one element per beat.
// Eight rows share one address (one word each); the row-batch base steps by n every eight rows.
module result_reader
    import result_reader_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  done_o,
    input  logic [ADDR_WIDTH-1:0] m_i,
    input  logic [ADDR_WIDTH-1:0] n_i,
    input  logic [ADDR_WIDTH-1:0] base_addrp_i,
    output logic                  enp_o,
    output logic                  wep_o,
    output logic [ADDR_WIDTH-1:0] addrp_o,
    input  logic [LINE_WIDTH-1:0] datap_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    state_t                state;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] m_q;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] i_q;
    logic [ADDR_WIDTH-1:0] j_q;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic                  issue_done_q;
    logic                  empty_job_q;

    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [2:0]            inflight_idx_q;

    beat_t                 push_beat;
    beat_t                 head;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic                  accept;
    logic                  last_elem;
    logic [2:0]            occupancy;
    logic                  issue;

    assign accept    = valid_o && ready_i;
    assign last_elem = (i_q == m_q - ADDR_WIDTH'(1)) && (j_q == n_q - ADDR_WIDTH'(1));

    // Reads in flight plus queued beats must never exceed the two FIFO slots,
    // counting the slot freed by a beat leaving this cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue     = (state == ST_BUSY) && !issue_done_q
                       && (occupancy < (3'd2 + {2'b00, accept}));

    assign enp_o   = issue;
    assign wep_o   = 1'b0;
    assign addrp_o = issue ? (row_base_q + j_q) : '0;

    assign push_beat.last = inflight_last_q;
    assign push_beat.word = select_word(datap_i, inflight_idx_q);

    assign valid_o = !fifo_empty;
    assign data_o  = valid_o ? head.word : '0;
    assign last_o  = valid_o && head.last;
    assign done_o  = done_q;

    fifo2 u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (inflight_q),
        .din    (push_beat),
        .pop    (accept),
        .head   (head),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= ST_IDLE;
            done_q          <= 1'b0;
            m_q             <= '0;
            n_q             <= '0;
            i_q             <= '0;
            j_q             <= '0;
            row_base_q      <= '0;
            issue_done_q    <= 1'b0;
            empty_job_q     <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_idx_q  <= 3'd0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_elem;
            inflight_idx_q  <= i_q[2:0];

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state        <= ST_BUSY;
                        m_q          <= m_i;
                        n_q          <= n_i;
                        row_base_q   <= base_addrp_i;
                        i_q          <= '0;
                        j_q          <= '0;
                        issue_done_q <= (m_i == '0) || (n_i == '0);
                        empty_job_q  <= (m_i == '0) || (n_i == '0);
                    end
                end

                ST_BUSY: begin
                    if (empty_job_q || (accept && head.last)) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                    // j runs fastest; crossing out of row 8k+7 moves to the next address batch.
                    if (issue) begin
                        if (last_elem) begin
                            issue_done_q <= 1'b1;
                        end else if (j_q == n_q - ADDR_WIDTH'(1)) begin
                            j_q <= '0;
                            i_q <= i_q + ADDR_WIDTH'(1);
                            if (i_q[2:0] == 3'd7) begin
                                row_base_q <= row_base_q + n_q;
                            end
                        end else begin
                            j_q <= j_q + ADDR_WIDTH'(1);
                        end
                    end
                end

                ST_DONE: begin
                    if (!start_i) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: a buffer P model answers reads, and expected
// addresses and beats are queued per job and compared as the DUT issues and streams them.
module tb_result_reader;
    import result_reader_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  start_i;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] m_i;
    logic [ADDR_WIDTH-1:0] n_i;
    logic [ADDR_WIDTH-1:0] base_addrp_i;
    logic                  enp_o;
    logic                  wep_o;
    logic [ADDR_WIDTH-1:0] addrp_o;
    logic [LINE_WIDTH-1:0] datap_i;
    logic [WORD_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  last_o;

    int testCount = 0;
    int failCount = 0;
    int cyc = 0;
    int beatCount = 0;
    int readCount = 0;
    int lastCycle = 0;
    bit readyRandom = 0;
    bit expectDoneTiming = 0;
    bit prevStall = 0;
    bit prevLast = 0;
    bit prevDone = 0;
    logic [WORD_WIDTH-1:0] prevData = '0;

    logic [ADDR_WIDTH-1:0] addrQ [$];
    logic [WORD_WIDTH:0]   expQ [$];

    result_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start_i),
        .done_o       (done_o),
        .m_i          (m_i),
        .n_i          (n_i),
        .base_addrp_i (base_addrp_i),
        .enp_o        (enp_o),
        .wep_o        (wep_o),
        .addrp_o      (addrp_o),
        .datap_i      (datap_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each stored word encodes its address and word slot so misrouted reads show up.
    function automatic logic [WORD_WIDTH-1:0] lineWord(input logic [ADDR_WIDTH-1:0] a, input int w);
        return {a, 8'(w), 8'hC3};
    endfunction

    always @(posedge clk) begin
        if (enp_o) begin
            for (int w = 0; w < LINE_WORDS; w++)
                datap_i[w*WORD_WIDTH +: WORD_WIDTH] <= lineWord(addrp_o, w);
        end
    end

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        logic [ADDR_WIDTH-1:0] ea;
        logic [WORD_WIDTH:0]   eb;
        if (!rst_n) begin
            prevStall = 0;
            prevDone  = 0;
        end else begin
            if (enp_o) begin
                readCount++;
                if (addrQ.size() == 0) begin
                    checkOutput("extraRead", 64'(addrp_o), 64'hFFFF_FFFF);
                end else begin
                    ea = addrQ.pop_front();
                    checkOutput("readAddr", 64'(addrp_o), 64'(ea));
                end
            end else begin
                checkOutput("addrIdle", 64'(addrp_o), 64'd0);
            end
            if (prevStall) begin
                checkOutput("stallValid", 64'(valid_o), 64'd1);
                checkOutput("stallData", 64'(data_o), 64'(prevData));
                checkOutput("stallLast", 64'(last_o), 64'(prevLast));
            end
            if (valid_o && ready_i) begin
                beatCount++;
                if (expQ.size() == 0) begin
                    checkOutput("extraBeat", 64'(data_o), 64'hFFFF_FFFF_FFFF);
                end else begin
                    eb = expQ.pop_front();
                    checkOutput("beatData", 64'(data_o), 64'(eb[WORD_WIDTH-1:0]));
                    checkOutput("beatLast", 64'(last_o), 64'(eb[WORD_WIDTH]));
                end
                if (last_o) lastCycle = cyc;
            end
            if (done_o && !prevDone && expectDoneTiming)
                checkOutput("doneTiming", 64'(cyc), 64'(lastCycle + 1));
            prevStall = valid_o && !ready_i;
            prevData  = data_o;
            prevLast  = last_o;
            prevDone  = done_o;
        end
    end

    task automatic queueJob(input int m, input int n, input logic [ADDR_WIDTH-1:0] base);
        logic [ADDR_WIDTH-1:0] a;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                a = ADDR_WIDTH'(int'(base) + (i / 8) * n + j);
                addrQ.push_back(a);
                expQ.push_back({(i == m - 1) && (j == n - 1), lineWord(a, i % 8)});
            end
        end
        readCount = 0;
        beatCount = 0;
        expectDoneTiming = (m != 0) && (n != 0);
    endtask

    task automatic applyStimulus(input int m, input int n, input logic [ADDR_WIDTH-1:0] base, input bit rnd);
        bit nz;
        int waited;
        nz = (m != 0) && (n != 0);
        readyRandom = rnd;
        queueJob(m, n, base);
        @(posedge clk);
        #1;
        m_i = ADDR_WIDTH'(m);
        n_i = ADDR_WIDTH'(n);
        base_addrp_i = base;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1Enp", 64'(enp_o), 64'(nz));
        checkOutput("t1Done", 64'(done_o), 64'd0);
        @(negedge clk);
        checkOutput("t2Valid", 64'(valid_o), 64'd0);
        checkOutput("t2Done", 64'(done_o), 64'(!nz));
        if (nz) begin
            @(negedge clk);
            checkOutput("t3Valid", 64'(valid_o), 64'd1);
        end
        waited = 0;
        while (!done_o && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("doneReached", 64'(done_o), 64'd1);
        checkOutput("beatTotal", 64'(beatCount), 64'(m * n));
        checkOutput("readTotal", 64'(readCount), 64'(m * n));
        checkOutput("expLeft", 64'(expQ.size()), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("doneHold", 64'(done_o), 64'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("doneDrop", 64'(done_o), 64'd0);
        readyRandom = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Done"},  64'(done_o),  64'd0);
        checkOutput({tag, "Enp"},   64'(enp_o),   64'd0);
        checkOutput({tag, "Wep"},   64'(wep_o),   64'd0);
        checkOutput({tag, "Addr"},  64'(addrp_o), 64'd0);
        checkOutput({tag, "Valid"}, 64'(valid_o), 64'd0);
        checkOutput({tag, "Data"},  64'(data_o),  64'd0);
        checkOutput({tag, "Last"},  64'(last_o),  64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        start_i = 1'b0;
        m_i = '0;
        n_i = '0;
        base_addrp_i = '0;
        datap_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("rst");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8, 8, 16'h0010, 1'b0);
        applyStimulus(9, 3, 16'h0000, 1'b0);
        applyStimulus(16, 5, 16'h0040, 1'b1);
        applyStimulus(0, 4, 16'h0005, 1'b0);
        applyStimulus(4, 0, 16'h0005, 1'b0);

        // Abort an 8x8 run after ten beats, then confirm a clean full rerun.
        queueJob(8, 8, 16'h0000);
        @(posedge clk);
        #1;
        m_i = 16'd8;
        n_i = 16'd8;
        base_addrp_i = 16'h0000;
        start_i = 1'b1;
        waited = 0;
        while (beatCount < 10 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("midBeats", 64'(beatCount >= 10), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midRst");
        addrQ.delete();
        expQ.delete();
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("heldRst");
        rst_n = 1'b1;
        applyStimulus(8, 8, 16'h0020, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
